fpd_result_fifo: RTL

- Registered output stage directly downstream of the floating-point divider (fpd).
- Accepts each fpd result word together with its overflow, underflow and divide-by-zero flags through a valid/ready handshake.
- Buffers accepted results in a small FIFO and presents them to the consumer through a second valid/ready handshake.
- Keeps sticky exception flags and a saturating exception counter for software/bench inspection.

---
 rtl/fpd_pkg.sv | 27 ++
 rtl/fpd_fifo_mem.sv | 33 +++
 rtl/fpd_result_fifo.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fpd_pkg.sv
// Shared types for the floating-point divider result path.
// The optional FPD_NAN_DETECT_EN macro adds a per-entry NaN flag to fpd_result_t.
package fpd_pkg;

    localparam int EXP_WIDTH      = 8;
    localparam int MANTISSA_WIDTH = 23;
    localparam int WIDTH          = EXP_WIDTH + MANTISSA_WIDTH + 1;

    typedef struct packed {
        logic                      sign;
        logic [EXP_WIDTH-1:0]      exponent;
        logic [MANTISSA_WIDTH-1:0] mantissa;
        logic                      overflow;
        logic                      underflow;
        logic                      dbz;
`ifdef FPD_NAN_DETECT_EN
        logic                      nan;
`endif
    } fpd_result_t;

    // Exponent all ones with a non-zero mantissa; infinities are not NaN.
    function automatic logic is_nan(input logic [WIDTH-1:0] word);
        return (word[WIDTH-2:MANTISSA_WIDTH] == {EXP_WIDTH{1'b1}}) &&
               (word[MANTISSA_WIDTH-1:0] != '0);
    endfunction

endpackage

// File: rtl/fpd_fifo_mem.sv
// DEPTH x fpd_result_t storage: one synchronous write port, one combinational read port.
module fpd_fifo_mem
    import fpd_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wr_en,
    input  logic [PTR_WIDTH-1:0] wr_addr,
    input  fpd_result_t          wr_data,
    input  logic [PTR_WIDTH-1:0] rd_addr,
    output fpd_result_t          rd_data
);

    fpd_result_t mem [DEPTH];

    // NOTE: the array is reset on purpose so the head outputs read 0 after reset
    // rather than stale or X contents; at this depth it is just a handful of flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fpd_result_fifo.sv
// Result FIFO behind the fpd divider with sticky exception flags and a saturating counter.
// Define FPD_NAN_DETECT_EN to add per-entry NaN detection (nan_out, sticky_nan_out).
module fpd_result_fifo
    import fpd_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [WIDTH-1:0]       fpd_in,
    input  logic                   overflow_in,
    input  logic                   underflow_in,
    input  logic                   dbz_in,
    input  logic                   in_valid_in,
    output logic                   in_ready_out,
    output logic [WIDTH-1:0]       fpd_out,
    output logic                   overflow_out,
    output logic                   underflow_out,
    output logic                   dbz_out,
    output logic                   out_valid_out,
    input  logic                   out_ready_in,
    input  logic                   clear_flags_in,
`ifdef FPD_NAN_DETECT_EN
    output logic                   nan_out,
    output logic                   sticky_nan_out,
`endif
    output logic                   sticky_overflow_out,
    output logic                   sticky_underflow_out,
    output logic                   sticky_dbz_out,
    output logic [COUNT_WIDTH-1:0] exc_count_out
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int OCC_WIDTH = PTR_WIDTH + 1;
    localparam logic [OCC_WIDTH-1:0] FULL = OCC_WIDTH'(DEPTH);

    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [OCC_WIDTH-1:0] count;
    logic                 push;
    logic                 pop;
    logic                 entry_flagged;
    fpd_result_t          wr_entry;
    fpd_result_t          head;

    // Handshakes depend only on registered occupancy, never on the inputs.
    assign in_ready_out  = (count != FULL);
    assign out_valid_out = (count != '0);
    assign push          = in_valid_in && in_ready_out;
    assign pop           = out_valid_out && out_ready_in;

    // NOTE: default every field first so no path through this block leaves a latch.
    always_comb begin
        wr_entry           = '0;
        wr_entry.sign      = fpd_in[WIDTH-1];
        wr_entry.exponent  = fpd_in[WIDTH-2:MANTISSA_WIDTH];
        wr_entry.mantissa  = fpd_in[MANTISSA_WIDTH-1:0];
        wr_entry.overflow  = overflow_in;
        wr_entry.underflow = underflow_in;
        wr_entry.dbz       = dbz_in;
`ifdef FPD_NAN_DETECT_EN
        wr_entry.nan       = is_nan(fpd_in);
`endif
    end

`ifdef FPD_NAN_DETECT_EN
    assign entry_flagged = wr_entry.overflow | wr_entry.underflow | wr_entry.dbz | wr_entry.nan;
`else
    assign entry_flagged = wr_entry.overflow | wr_entry.underflow | wr_entry.dbz;
`endif

    fpd_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (head)
    );

    assign fpd_out       = {head.sign, head.exponent, head.mantissa};
    assign overflow_out  = head.overflow;
    assign underflow_out = head.underflow;
    assign dbz_out       = head.dbz;
`ifdef FPD_NAN_DETECT_EN
    assign nan_out       = head.nan;
`endif

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
            case ({push, pop})
                2'b10:   count <= count + OCC_WIDTH'(1);
                2'b01:   count <= count - OCC_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    // Clear drops the old sticky state; an accepted push in the same cycle still sets its flags.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sticky_overflow_out  <= 1'b0;
            sticky_underflow_out <= 1'b0;
            sticky_dbz_out       <= 1'b0;
`ifdef FPD_NAN_DETECT_EN
            sticky_nan_out       <= 1'b0;
`endif
        end else begin
            sticky_overflow_out  <= (sticky_overflow_out  & ~clear_flags_in) | (push & wr_entry.overflow);
            sticky_underflow_out <= (sticky_underflow_out & ~clear_flags_in) | (push & wr_entry.underflow);
            sticky_dbz_out       <= (sticky_dbz_out       & ~clear_flags_in) | (push & wr_entry.dbz);
`ifdef FPD_NAN_DETECT_EN
            sticky_nan_out       <= (sticky_nan_out       & ~clear_flags_in) | (push & wr_entry.nan);
`endif
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            exc_count_out <= '0;
        end else if (push && entry_flagged) begin
            if (clear_flags_in)
                exc_count_out <= COUNT_WIDTH'(1);
            else if (exc_count_out != '1)
                exc_count_out <= exc_count_out + COUNT_WIDTH'(1);
        end else if (clear_flags_in) begin
            exc_count_out <= '0;
        end
    end

endmodule
